// File: rtl/sram_port_arbiter_if.sv
// Two requester ports and the shared single-port SRAM bus around sram_port_arbiter.
interface sram_port_arbiter_if #(
    parameter int MEM_AWIDTH = 9
);
    logic                  pA_req, pA_we, pA_gnt, pA_rvalid;
    logic [MEM_AWIDTH-1:0] pA_addr;
    logic [3:0]            pA_byteen;
    logic [31:0]           pA_wdata, pA_rdata;

    logic                  pB_req, pB_we, pB_gnt, pB_rvalid;
    logic [MEM_AWIDTH-1:0] pB_addr;
    logic [3:0]            pB_byteen;
    logic [31:0]           pB_wdata, pB_rdata;

    logic                  mem_ren, mem_wen;
    logic [MEM_AWIDTH-1:0] mem_addr;
    logic [3:0]            mem_byteen;
    logic [31:0]           mem_wdata, mem_rdata;

    modport slave (
        input  pA_req, pA_we, pA_addr, pA_byteen, pA_wdata,
        input  pB_req, pB_we, pB_addr, pB_byteen, pB_wdata,
        input  mem_rdata,
        output pA_gnt, pA_rvalid, pA_rdata,
        output pB_gnt, pB_rvalid, pB_rdata,
        output mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata
    );

    modport master (
        output pA_req, pA_we, pA_addr, pA_byteen, pA_wdata,
        output pB_req, pB_we, pB_addr, pB_byteen, pB_wdata,
        input  pA_gnt, pA_rvalid, pA_rdata,
        input  pB_gnt, pB_rvalid, pB_rdata
    );

    modport mem (
        input  mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port to single-port SRAM arbiter: sticky owner with a bounded hold count,
// plus a read-return tag pipeline that steers rvalid back to the issuing port.
module sram_port_arbiter #(
    parameter int MEM_AWIDTH = 9,
    parameter int MEM_RD_LAT = 1,
    parameter int MAX_HOLD   = 4
) (
    input  logic               HCLK,
    input  logic               HRESET,
    sram_port_arbiter_if.slave bus
);
    typedef enum logic {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_e;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    owner_e                owner_q, owner_d;
    logic [3:0]            hold_cnt_q, hold_cnt_d;
    logic [MEM_RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [MEM_RD_LAT-1:0] tag_b_q, tag_b_d;

    logic req_a, req_b, gnt_a, gnt_b, any_gnt, sel_we, rd_issue, keep_owner;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        keep_owner = hold_cnt_q < HOLD_MAX;

        // Requests are masked during reset so nothing reaches the SRAM.
        req_a = bus.pA_req & ~HRESET;
        req_b = bus.pB_req & ~HRESET;

        if (req_a && req_b) begin
            if (owner_q == OWNER_A) begin
                gnt_a = keep_owner;
                gnt_b = ~keep_owner;
            end else begin
                gnt_b = keep_owner;
                gnt_a = ~keep_owner;
            end
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end

        if (gnt_a || gnt_b) begin
            if (gnt_b == (owner_q == OWNER_B)) begin
                if (keep_owner) hold_cnt_d = hold_cnt_q + 4'd1;
            end else begin
                owner_d    = gnt_b ? OWNER_B : OWNER_A;
                hold_cnt_d = 4'd1;
            end
        end
    end

    assign any_gnt  = gnt_a | gnt_b;
    assign sel_we   = gnt_b ? bus.pB_we : bus.pA_we;
    assign rd_issue = any_gnt & ~sel_we;

    // Idle cycles park the address/data mux on port A.
    assign bus.pA_gnt     = gnt_a;
    assign bus.pB_gnt     = gnt_b;
    assign bus.mem_ren    = rd_issue;
    assign bus.mem_wen    = any_gnt & sel_we;
    assign bus.mem_addr   = gnt_b ? bus.pB_addr  : bus.pA_addr;
    assign bus.mem_wdata  = gnt_b ? bus.pB_wdata : bus.pA_wdata;
    assign bus.mem_byteen = gnt_b ? bus.pB_byteen : (gnt_a ? bus.pA_byteen : 4'b0000);

    generate
        if (MEM_RD_LAT == 1) begin : g_tag_lat1
            assign tag_vld_d = rd_issue;
            assign tag_b_d   = gnt_b;
        end else begin : g_tag_latn
            assign tag_vld_d = {tag_vld_q[MEM_RD_LAT-2:0], rd_issue};
            assign tag_b_d   = {tag_b_q[MEM_RD_LAT-2:0], gnt_b};
        end
    endgenerate

    assign bus.pA_rvalid = tag_vld_q[MEM_RD_LAT-1] & ~tag_b_q[MEM_RD_LAT-1];
    assign bus.pB_rvalid = tag_vld_q[MEM_RD_LAT-1] &  tag_b_q[MEM_RD_LAT-1];
    assign bus.pA_rdata  = bus.mem_rdata;
    assign bus.pB_rdata  = bus.mem_rdata;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            owner_q    <= OWNER_A;
            hold_cnt_q <= 4'd0;
            tag_vld_q  <= '0;
            tag_b_q    <= '0;
        end else begin
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_b_q    <= tag_b_d;
        end
    end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter MEM_AWIDTH, default 9, SHALL set the fabric SRAM word-address width (512-word memory).
REQ-002 Parameter MEM_RD_LAT, default 1, legal 1..2, SHALL set the SRAM read latency in HCLK cycles from mem_ren to valid mem_rdata.
REQ-003 Parameter MAX_HOLD, default 4, legal 1..15, SHALL set the maximum consecutive grants the owner keeps while the other port waits.
REQ-004 HCLK  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-005 HRESET  input  1  reset, asynchronous and active-high.
REQ-006 pA_req / pB_req  input  1  access request, held until granted.
REQ-007 pA_we / pB_we  input  1  1 = write, 0 = read.
REQ-008 pA_addr / pB_addr  input  MEM_AWIDTH  word address.
REQ-009 pA_byteen / pB_byteen  input  4  byte enables; used on writes only.
REQ-010 pA_wdata / pB_wdata  input  32  write data.
REQ-011 pA_gnt / pB_gnt  output  1  access accepted this cycle (combinational).
REQ-012 pA_rvalid / pB_rvalid  output  1  read data valid for that port.
REQ-013 pA_rdata / pB_rdata  output  32  read data, driven from mem_rdata.
REQ-014 mem_ren, mem_wen  output  1  SRAM read/write strobes.
REQ-015 mem_addr  output  MEM_AWIDTH; mem_byteen  output  4; mem_wdata  output  32; all to SRAM.
REQ-016 mem_rdata  input  32  SRAM read data.

Function
REQ-017 At most one of pA_gnt/pB_gnt SHALL be 1 in any cycle; gnt SHALL never be 1 without the matching req.
REQ-018 Only one port requesting -> that port SHALL be granted in the same cycle.
REQ-019 Both requesting -> the owner SHALL be granted if hold_cnt < MAX_HOLD, otherwise the non-owner SHALL be granted.
REQ-020 On a grant to the owner, hold_cnt SHALL increment, saturating at MAX_HOLD; on a grant to the non-owner, owner SHALL switch to that port and hold_cnt SHALL become 1.
REQ-021 In cycles with no grant, owner and hold_cnt SHALL hold their values.
REQ-022 In a granted cycle, mem_addr/mem_byteen/mem_wdata SHALL carry the granted port's inputs; mem_wen = we, mem_ren = !we.
REQ-023 With no grant: mem_ren = mem_wen = 0, mem_byteen = 0; mem_addr and mem_wdata SHALL carry port A's inputs.
REQ-024 For a read granted in cycle N, the issuing port's rvalid SHALL be 1 in cycle N+MEM_RD_LAT only, with rdata = mem_rdata in that cycle.
REQ-025 The read-return tag pipeline, MEM_RD_LAT deep, SHALL track the issuing port so that back-to-back reads from alternating ports return to the correct port.
REQ-026 pA_rdata and pB_rdata SHALL both be driven from mem_rdata continuously; only rvalid qualifies them.
REQ-027 Writes SHALL produce no rvalid.
REQ-028 A write and a read to the same address in consecutive cycles SHALL be issued in grant order; data hazards are the SRAM's behaviour, not this block's.

Reset
REQ-029 HRESET = 1 SHALL asynchronously set owner = A, hold_cnt = 0, and clear the tag pipeline; pA_rvalid = pB_rvalid = 0.
REQ-030 While HRESET = 1, pA_gnt = pB_gnt = 0 and mem_ren = mem_wen = 0 regardless of requests.
REQ-031 Reads in flight when HRESET asserts SHALL produce no rvalid after reset is released.
REQ-032 The first cycle after release SHALL arbitrate normally; a request present in that cycle is granted under REQ-018/REQ-019.

Verification
REQ-033 Port A only, read addr 0x010 with MEM_RD_LAT = 1, SRAM returning 0xDEADBEEF -> pA_gnt and mem_ren in cycle N; pA_rvalid = 1 with pA_rdata = 0xDEADBEEF in N+1; pB_rvalid stays 0.
REQ-034 Both ports request continuously from reset, MAX_HOLD = 4 -> grant sequence A,A,A,A,B,B,B,B,A...; no two gnts in one cycle.
REQ-035 Alternating reads A@0x001, B@0x002, A@0x003 in consecutive cycles, MEM_RD_LAT = 2 -> rvalid on A, B, A in cycles N+2, N+3, N+4 with the matching data.
REQ-036 Port B write, addr 0x1FF, byteen 4'b0101, wdata 0x12345678 -> mem_wen = 1, mem_addr = 0x1FF, mem_byteen = 4'b0101, mem_wdata = 0x12345678 in the grant cycle; no rvalid follows.
REQ-037 Port A read granted, then HRESET pulsed in the next cycle -> pA_rvalid never asserts; owner = A and hold_cnt = 0 after release.
REQ-038 Port A requests alone for 10 cycles, then B joins -> hold_cnt is saturated at MAX_HOLD, so B is granted in the first contended cycle.
